apb_adc_drain_master: RTL and testbench
=======================================

Name: apb_adc_drain_master

Overview:
APB initiator that empties the ADC sample FIFO without CPU involvement. On a rising edge of the ADC half or full interrupt, it reads the ADC FIFO state register. It then issues single APB reads of the ADC data register, one per buffered sample, and streams each 14-bit sample out on a valid/ready port. It can also issue one APB write to the ADC control register on request, for example to start a conversion. It sits on the peripheral APB as a second initiator, in front of the ADC control slave.

Parameters:
APB_ADDR_WIDTH, 32, width of paddr.
ADC_BA, 32'h1B00_4000, ADC slave base address.
BURST_MAX, 16, maximum samples drained per trigger (range 1..65535).
TIMEOUT, 255, maximum ACCESS-phase wait cycles for pready before abort (8-bit counter).

Ports:
pclk  in  1  APB clock; all logic on the rising edge.
prst_n  in  1  asynchronous active-low reset.
en  in  1  enables trigger capture.
adc_half_interrupt  in  1  level interrupt from the ADC slave.
adc_full_interrupt  in  1  level interrupt from the ADC slave.
ctl_go  in  1  single-cycle pulse: request a write of ctl_wdata.
ctl_wdata  in  32  data for the ADC_CTL_REG write.
paddr  out  APB_ADDR_WIDTH  APB address.
psel  out  1  APB select.
penable  out  1  APB enable.
pwrite  out  1  APB direction.
pwdata  out  32  APB write data.
prdata  in  32  APB read data.
pready  in  1  APB ready.
pslverr  in  1  APB error.
smp_valid  out  1  sample available.
smp_data  out  14  sample value.
smp_ready  in  1  sink accepts sample.
busy  out  1  FSM not in IDLE.
err  out  1  sticky error flag; cleared only by reset.
drained_cnt  out  16  total samples pushed, wraps at 16'hFFFF.

Behaviour:
- Reset (async, prst_n=0): all outputs 0, FSM IDLE, pending flags 0, internal counters 0. Asserting reset mid-transfer drops psel/penable immediately; no completion of the transfer is required.
- Register addresses:
  - FIFO state: ADC_BA+'h14.
  - Data: ADC_BA+'h10.
  - Control: ADC_BA+'h0C.
- Triggers:
  - Edge detect: trig = en & (rising edge of half | rising edge of full), using 1-cycle registered copies of each interrupt.
  - trig sets drain_pend.
  - ctl_go sets ctl_pend. ctl_go is captured even when en=0.
  - Both pending flags are captured in any state, including while busy.
- IDLE:
  - ctl_pend has priority: clear it, then start a write to Control.
  - Else if drain_pend: clear it, then start a read of FIFO state.
- APB transfer (all transfers):
  - SETUP, 1 cycle: psel=1, penable=0, paddr/pwrite/pwdata stable.
  - ACCESS: psel=1, penable=1. The transfer completes on the first cycle with pready=1.
  - On completion, penable drops the next cycle. penable is never high for 2 cycles on one completed transfer; the slave pops its FIFO on every penable-high read cycle.
  - pwdata = 0 on reads. pwrite = 1 only for the Control write.
  - After completion: psel=0 for 1 cycle before the next SETUP.
- ACCESS wait counter:
  - Increments while pready=0.
  - Reaching TIMEOUT: set err, drop psel/penable, go to IDLE. Any remaining drain is abandoned.
- Completion with pslverr=1: set err, go to IDLE. Sampled prdata is ignored.
- State read (FIFO state complete):
  - cnt = prdata[31:16], empty = prdata[1].
  - If empty or cnt==0: go to IDLE.
  - Else remaining = min(cnt, BURST_MAX), then read Data.
- Data read complete:
  - Latch prdata[13:0] into smp_data, assert smp_valid, enter PUSH. No further APB transfer occurs while smp_valid=1 (backpressure).
- PUSH:
  - When smp_valid & smp_ready: drop smp_valid next cycle, drained_cnt+1, remaining-1.
  - If remaining (after decrement) is 0: IDLE. Else read Data again.
  - Minimum throughput: 1 sample per 4 cycles (gap, SETUP, ACCESS, PUSH) with pready=1 and smp_ready=1.
- Trigger during a drain: drain_pend re-arms. One extra FIFO-state read is issued after returning to IDLE; no samples are lost or duplicated.
- busy = (state != IDLE).

Test Plan:
- Write path: ctl_go with ctl_wdata=32'h0000_000F, pready=1 → one write with paddr=1B00_400C, pwrite=1, pwdata=0000_000F; busy high for 3 cycles.
- Normal drain: half rising; state prdata=0008_0000 (cnt=8); data reads return 'h0..'h7 → exactly 8 Data reads, 8 samples 0..7 in order, drained_cnt=8, penable high exactly 1 cycle per read.
- Clamp: cnt=40, BURST_MAX=16 → 16 Data reads only; idle afterwards.
- Backpressure: smp_ready low for 10 cycles after the first sample → no APB activity during the stall; smp_data held stable.
- Empty: state prdata=0000_0002 → no Data read; busy drops.
- Error: pready held low for TIMEOUT+1 cycles → err=1, psel=0. pslverr=1 on the 3rd Data read → err=1, drained_cnt=2.
- Async reset asserted during ACCESS → psel, penable, smp_valid and busy all 0 immediately.

Source files
------------

// File: rtl/apb_adc_drain_master_if.sv
// APB initiator bus and sample stream of the ADC drain master.
interface apb_adc_drain_master_if #(
    parameter int APB_ADDR_WIDTH = 32
);
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [31:0]               pwdata;
    logic [31:0]               prdata;
    logic                      pready;
    logic                      pslverr;
    logic                      smp_valid;
    logic [13:0]               smp_data;
    logic                      smp_ready;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr,
        output smp_valid, smp_data,
        input  smp_ready
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr,
        input  smp_valid, smp_data,
        output smp_ready
    );
endinterface

// File: rtl/apb_adc_drain_master.sv
// APB initiator draining the ADC sample FIFO into a valid/ready
// stream, with an on-demand write to the ADC control register.
module apb_adc_drain_master #(
    parameter int          APB_ADDR_WIDTH = 32,
    parameter logic [31:0] ADC_BA         = 32'h1B00_4000,
    parameter int          BURST_MAX      = 16,
    parameter int          TIMEOUT        = 255
) (
    input  logic        pclk,
    input  logic        prst_n,
    input  logic        en,
    input  logic        adc_half_interrupt,
    input  logic        adc_full_interrupt,
    input  logic        ctl_go,
    input  logic [31:0] ctl_wdata,
    apb_adc_drain_master_if.master bus,
    output logic        busy,
    output logic        err,
    output logic [15:0] drained_cnt
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_PUSH,
        S_GAP
    } state_t;

    typedef enum logic [1:0] {
        K_CTL,
        K_STAT,
        K_DATA
    } kind_t;

    localparam int AW = APB_ADDR_WIDTH;
    localparam logic [AW-1:0] A_CTL  = AW'(ADC_BA + 32'h0C);
    localparam logic [AW-1:0] A_DATA = AW'(ADC_BA + 32'h10);
    localparam logic [AW-1:0] A_STAT = AW'(ADC_BA + 32'h14);
    localparam logic [15:0]   BMAX   = 16'(BURST_MAX);
    localparam logic [7:0]    TO_END = 8'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    kind_t       kind_q;
    logic        half_q;
    logic        full_q;
    logic        drain_pend;
    logic        ctl_pend;
    logic [31:0] ctl_data;
    logic [31:0] wdata_q;
    logic [15:0] remaining;
    logic [7:0]  wait_cnt;
    logic [13:0] smp_q;
    logic [AW-1:0] addr;

    logic        trig;
    logic        sel;
    logic        done;
    logic        tmo;
    logic        fail;
    logic        ok;
    logic        start_ctl;
    logic        start_drain;
    logic        pop;
    logic [15:0] fifo_cnt;
    logic        fifo_empty;
    logic        unused_bits;

    assign trig = en & ((adc_half_interrupt & ~half_q)
                      | (adc_full_interrupt & ~full_q));

    assign sel  = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign done = (state_q == S_ACCESS) && bus.pready;
    assign fail = done && bus.pslverr;
    assign ok   = done && !bus.pslverr;
    assign tmo  = (state_q == S_ACCESS) && !bus.pready
               && (wait_cnt == TO_END);

    assign start_ctl   = (state_q == S_IDLE) && ctl_pend;
    assign start_drain = (state_q == S_IDLE) && !ctl_pend
                      && drain_pend;
    assign pop = (state_q == S_PUSH) && bus.smp_ready;

    assign fifo_cnt    = bus.prdata[31:16];
    assign fifo_empty  = bus.prdata[1];
    assign unused_bits = &{1'b0, bus.prdata[15:14]};

    always_comb begin
        addr = A_DATA;
        unique case (1'b1)
            kind_q == K_CTL:  addr = A_CTL;
            kind_q == K_STAT: addr = A_STAT;
            default:          addr = A_DATA;
        endcase
    end

    assign bus.psel      = sel;
    assign bus.penable   = (state_q == S_ACCESS);
    assign bus.pwrite    = sel && (kind_q == K_CTL);
    assign bus.paddr     = sel ? addr : '0;
    assign bus.pwdata    = (sel && kind_q == K_CTL) ? wdata_q : '0;
    assign bus.smp_valid = (state_q == S_PUSH);
    assign bus.smp_data  = smp_q;
    assign busy          = (state_q != S_IDLE);

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // After a data read the FSM parks in PUSH until the sink takes it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (ctl_pend || drain_pend) state_d = S_SETUP;
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (tmo || fail) begin
                    state_d = S_IDLE;
                end else if (done) begin
                    state_d = (kind_q == K_DATA) ? S_PUSH : S_GAP;
                end
            end
            S_PUSH: begin
                if (bus.smp_ready) begin
                    state_d = (remaining == 16'd1) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (kind_q == K_DATA && remaining != '0) begin
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            half_q      <= 1'b0;
            full_q      <= 1'b0;
            drain_pend  <= 1'b0;
            ctl_pend    <= 1'b0;
            ctl_data    <= '0;
            wdata_q     <= '0;
            kind_q      <= K_CTL;
            remaining   <= '0;
            wait_cnt    <= '0;
            smp_q       <= '0;
            err         <= 1'b0;
            drained_cnt <= '0;
        end else begin
            half_q <= adc_half_interrupt;
            full_q <= adc_full_interrupt;

            // A new request in the same cycle it is taken re-arms it.
            if (trig) begin
                drain_pend <= 1'b1;
            end else if (start_drain) begin
                drain_pend <= 1'b0;
            end

            if (ctl_go) begin
                ctl_pend <= 1'b1;
                ctl_data <= ctl_wdata;
            end else if (start_ctl) begin
                ctl_pend <= 1'b0;
            end

            if (start_ctl) begin
                kind_q  <= K_CTL;
                wdata_q <= ctl_data;
            end else if (start_drain) begin
                kind_q <= K_STAT;
            end

            if (state_q == S_SETUP) begin
                wait_cnt <= '0;
            end else if (state_q == S_ACCESS && !bus.pready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (tmo || fail) err <= 1'b1;

            if (ok && kind_q == K_STAT) begin
                if (!fifo_empty && fifo_cnt != '0) begin
                    remaining <= (fifo_cnt > BMAX) ? BMAX : fifo_cnt;
                    kind_q    <= K_DATA;
                end
            end

            if (ok && kind_q == K_DATA) smp_q <= bus.prdata[13:0];

            if (pop) begin
                drained_cnt <= drained_cnt + 16'd1;
                remaining   <= remaining - 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_apb_adc_drain_master.sv
// Directed bench for apb_adc_drain_master with a small APB slave
// whose data register returns a running read index.
module tb_apb_adc_drain_master;
    localparam logic [31:0] A_CTL  = 32'h1B00_400C;
    localparam logic [31:0] A_DATA = 32'h1B00_4010;
    localparam logic [31:0] A_STAT = 32'h1B00_4014;

    logic        pclk = 1'b0;
    logic        prst_n = 1'b0;
    logic        en = 1'b0;
    logic        half = 1'b0;
    logic        full = 1'b0;
    logic        ctl_go = 1'b0;
    logic [31:0] ctl_wdata = '0;
    logic        busy;
    logic        err;
    logic [15:0] drained_cnt;

    logic        rdy = 1'b1;
    logic        srdy = 1'b1;
    logic [31:0] stat_val = '0;
    int          didx = 0;
    int          err_at = -1;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int pen_cyc = 0;
    int pen_viol = 0;
    int busy_cyc = 0;
    int wr_cnt = 0;
    int st_cnt = 0;
    int rd_cnt = 0;
    int stall_viol = 0;
    int first_push = 0;
    int last_push = 0;
    logic prev_done = 1'b0;
    logic [31:0] waddr = '0;
    logic [31:0] wdat = '0;
    logic [13:0] smp_q[$];

    apb_adc_drain_master_if #(.APB_ADDR_WIDTH(32)) bus ();

    apb_adc_drain_master dut (
        .pclk               (pclk),
        .prst_n             (prst_n),
        .en                 (en),
        .adc_half_interrupt (half),
        .adc_full_interrupt (full),
        .ctl_go             (ctl_go),
        .ctl_wdata          (ctl_wdata),
        .bus                (bus),
        .busy               (busy),
        .err                (err),
        .drained_cnt        (drained_cnt)
    );

    always #5 pclk = ~pclk;

    assign bus.pready    = rdy;
    assign bus.smp_ready = srdy;
    assign bus.prdata    = (bus.paddr == A_STAT) ? stat_val
                         : (bus.paddr == A_DATA) ? 32'(didx) : '0;
    assign bus.pslverr   = bus.psel && bus.penable
                         && (bus.paddr == A_DATA) && (didx == err_at);

    always @(posedge pclk) begin
        if (bus.psel && bus.penable && bus.pready && !bus.pwrite
            && bus.paddr == A_DATA) didx <= didx + 1;
    end

    always @(negedge pclk) begin
        cyc++;
        if (busy) busy_cyc++;
        if (bus.penable) pen_cyc++;
        if (bus.penable && prev_done) pen_viol++;
        prev_done = bus.psel && bus.penable && bus.pready;
        if (prev_done) begin
            if (bus.pwrite) begin
                wr_cnt++;
                waddr = bus.paddr;
                wdat  = bus.pwdata;
            end else if (bus.paddr == A_STAT) begin
                st_cnt++;
            end else if (bus.paddr == A_DATA) begin
                rd_cnt++;
            end
        end
        if (bus.smp_valid && bus.psel) stall_viol++;
        if (bus.smp_valid && bus.smp_ready) begin
            smp_q.push_back(bus.smp_data);
            if (smp_q.size() == 1) first_push = cyc;
            last_push = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 2000) begin
            @(negedge pclk);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        chk({tag, "_bound"}, 32'(n < 2000), 32'd1);
        tick(1);
    endtask

    task automatic wait_pen(input string tag);
        int n = 0;
        while (!bus.penable && n < 50) begin
            @(negedge pclk);
            n++;
        end
        chk({tag, "_bound"}, 32'(bus.penable), 32'd1);
    endtask

    task automatic chk_smp(input string tag, input int base,
                           input int n);
        chk({tag, "_n"}, 32'(smp_q.size()), 32'(n));
        for (int i = 0; i < n && i < smp_q.size(); i++) begin
            chk(tag, 32'(smp_q[i]), 32'(base + i));
        end
    endtask

    initial begin
        int b0;
        int w0;
        int s0;
        int r0;
        int p0;
        int v0;
        int chg;
        logic [13:0] d0;

        tick(2);
        chk("rst_psel", 32'(bus.psel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        prst_n = 1'b1;
        tick(2);
        chk("idle_penable", 32'(bus.penable), 32'd0);
        chk("idle_valid", 32'(bus.smp_valid), 32'd0);
        chk("idle_err", 32'(err), 32'd0);
        chk("idle_cnt", 32'(drained_cnt), 32'd0);
        chk("idle_paddr", bus.paddr, 32'd0);
        en = 1'b1;

        // control write
        b0 = busy_cyc;
        w0 = wr_cnt;
        ctl_wdata = 32'h0000_000F;
        ctl_go = 1'b1;
        tick(1);
        ctl_go = 1'b0;
        ctl_wdata = 32'hDEAD_BEEF;
        wait_idle("wr");
        chk("wr_count", 32'(wr_cnt - w0), 32'd1);
        chk("wr_addr", waddr, A_CTL);
        chk("wr_data", wdat, 32'h0000_000F);
        chk("wr_busy", 32'(busy_cyc - b0), 32'd3);

        // normal drain of 8
        smp_q.delete();
        stat_val = 32'h0008_0000;
        s0 = st_cnt;
        r0 = rd_cnt;
        p0 = pen_cyc;
        half = 1'b1;
        wait_idle("drain");
        half = 1'b0;
        chk("drain_st", 32'(st_cnt - s0), 32'd1);
        chk("drain_rd", 32'(rd_cnt - r0), 32'd8);
        chk("drain_pen", 32'(pen_cyc - p0), 32'd9);
        chk("drain_cnt", 32'(drained_cnt), 32'd8);
        chk("drain_tput", 32'(last_push - first_push), 32'd28);
        chk_smp("drain_smp", 0, 8);

        // clamp 40 to 16
        smp_q.delete();
        stat_val = 32'h0028_0000;
        s0 = st_cnt;
        r0 = rd_cnt;
        full = 1'b1;
        wait_idle("clamp");
        full = 1'b0;
        chk("clamp_st", 32'(st_cnt - s0), 32'd1);
        chk("clamp_rd", 32'(rd_cnt - r0), 32'd16);
        chk("clamp_cnt", 32'(drained_cnt), 32'd24);
        chk("clamp_busy", 32'(busy), 32'd0);
        chk_smp("clamp_smp", 8, 16);

        // backpressure on first sample
        smp_q.delete();
        stat_val = 32'h0003_0000;
        srdy = 1'b0;
        v0 = stall_viol;
        half = 1'b1;
        begin
            int n = 0;
            while (!bus.smp_valid && n < 50) begin
                @(negedge pclk);
                n++;
            end
        end
        chk("bp_valid", 32'(bus.smp_valid), 32'd1);
        d0 = bus.smp_data;
        r0 = rd_cnt;
        chg = 0;
        repeat (10) begin
            @(negedge pclk);
            if (bus.smp_data !== d0 || !bus.smp_valid) chg++;
        end
        chk("bp_first", 32'(d0), 32'd24);
        chk("bp_held", 32'(chg), 32'd0);
        chk("bp_quiet", 32'(rd_cnt - r0), 32'd0);
        tick(1);
        srdy = 1'b1;
        wait_idle("bp");
        half = 1'b0;
        chk("bp_viol", 32'(stall_viol - v0), 32'd0);
        chk("bp_cnt", 32'(drained_cnt), 32'd27);
        chk_smp("bp_smp", 24, 3);

        // empty FIFO
        stat_val = 32'h0000_0002;
        s0 = st_cnt;
        r0 = rd_cnt;
        tick(1);
        half = 1'b1;
        wait_idle("empty");
        half = 1'b0;
        chk("empty_st", 32'(st_cnt - s0), 32'd1);
        chk("empty_rd", 32'(rd_cnt - r0), 32'd0);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_cnt", 32'(drained_cnt), 32'd27);
        chk("empty_err", 32'(err), 32'd0);

        // ACCESS timeout
        stat_val = 32'h0004_0000;
        rdy = 1'b0;
        tick(1);
        half = 1'b1;
        wait_pen("to_pen");
        begin
            int n = 0;
            while (bus.penable && n < 400) begin
                n++;
                @(negedge pclk);
            end
            chk("to_cycles", 32'(n), 32'd255);
        end
        chk("to_err", 32'(err), 32'd1);
        chk("to_psel", 32'(bus.psel), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        tick(1);
        rdy = 1'b1;
        half = 1'b0;
        tick(2);
        prst_n = 1'b0;
        tick(1);
        chk("rst2_err", 32'(err), 32'd0);
        chk("rst2_cnt", 32'(drained_cnt), 32'd0);
        prst_n = 1'b1;
        tick(1);

        // slave error on third data read
        smp_q.delete();
        stat_val = 32'h0005_0000;
        err_at = didx + 2;
        r0 = rd_cnt;
        half = 1'b1;
        wait_idle("slv");
        half = 1'b0;
        chk("slv_err", 32'(err), 32'd1);
        chk("slv_cnt", 32'(drained_cnt), 32'd2);
        chk("slv_rd", 32'(rd_cnt - r0), 32'd3);
        chk_smp("slv_smp", 27, 2);
        err_at = -1;

        // async reset during ACCESS
        rdy = 1'b0;
        stat_val = 32'h0002_0000;
        tick(1);
        full = 1'b1;
        wait_pen("ar_pen");
        #2;
        prst_n = 1'b0;
        full = 1'b0;
        #1;
        chk("ar_psel", 32'(bus.psel), 32'd0);
        chk("ar_penable", 32'(bus.penable), 32'd0);
        chk("ar_valid", 32'(bus.smp_valid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        rdy = 1'b1;
        tick(2);
        prst_n = 1'b1;
        tick(2);
        chk("ar_idle", 32'(busy), 32'd0);
        chk("pen_once", 32'(pen_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
